// File: rtl/ddr2_traffic_gen_if.sv
// Host-side bundle between the traffic generator and the DDR2 controller.
// The generator uses the master view; a controller or model uses the slave view.
interface ddr2_traffic_gen_if #(
  parameter int DW  = 16,
  parameter int AW  = 25,
  parameter int FCW = 7
);
  logic [2:0]     CMD;
  logic [1:0]     SZ;
  logic [2:0]     OP;
  logic [DW-1:0]  DIN;
  logic [AW-1:0]  ADDR;
  logic           FETCHING;
  logic [FCW-1:0] FILLCOUNT;
  logic           NOTFULL;
  logic [DW-1:0]  DOUT;
  logic [AW-1:0]  RADDR;
  logic           VALIDOUT;

  modport master (
    output CMD, SZ, OP, DIN, ADDR, FETCHING,
    input  FILLCOUNT, NOTFULL, DOUT, RADDR, VALIDOUT
  );

  modport slave (
    input  CMD, SZ, OP, DIN, ADDR, FETCHING,
    output FILLCOUNT, NOTFULL, DOUT, RADDR, VALIDOUT
  );
endinterface

// File: rtl/ddr2_traffic_gen.sv
// DDR2 host traffic generator and read-back checker.
// Writes NUM_BLK blocks of BL words with a known pattern, reads them back
// with one block-read command per block, and checks every returned word
// against the pattern value derived from its RADDR.
module ddr2_traffic_gen #(
  parameter int            DW         = 16,
  parameter int            AW         = 25,
  parameter int            FCW        = 7,
  parameter int            FIFO_DEPTH = 64,
  parameter int            NUM_BLK    = 4,
  parameter logic [1:0]    SZ_CODE    = 2'd0,
  parameter int            MODE       = 0,
  parameter logic [15:0]   SEED       = 16'hA5C3,
  parameter logic [AW-1:0] BASE_ADDR  = '0,
  parameter logic [2:0]    CMD_BLW    = 3'b100,
  parameter logic [2:0]    CMD_BLR    = 3'b011,
  parameter logic [2:0]    CMD_NOP    = 3'b000,
  parameter int            TIMEOUT    = 4096
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  input  logic          READY,
  ddr2_traffic_gen_if.master host,
  output logic          BUSY,
  output logic          DONE,
  output logic          PASS,
  output logic          TIMED_OUT,
  output logic [15:0]   ERR_CNT,
  output logic [15:0]   RD_CNT,
  output logic [AW-1:0] FIRST_ERR_ADDR
);

  localparam int          BL       = 8 * (int'(SZ_CODE) + 1);
  localparam int          WR_LIMIT = FIFO_DEPTH - BL - 2;  // room for a whole burst plus slack
  localparam int          RD_LIMIT = FIFO_DEPTH - 2;
  localparam logic [15:0] TOTAL    = 16'(NUM_BLK * BL);

  typedef enum logic [2:0] {
    IDLE, WAIT_RDY, WR_GATE, WR_BURST, RD_GATE, RD_ISSUE, DRAIN, DONE_S
  } state_t;

  state_t        state_q, state_d;
  logic [10:0]   blk_q, blk_d;
  logic [5:0]    word_q, word_d;
  logic [31:0]   drain_q, drain_d;
  logic [2:0]    cmd_q, cmd_d;
  logic [1:0]    sz_q;
  logic          fetching_q, fetching_d;
  logic [DW-1:0] din_q, din_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          timed_out_q, timed_out_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic [15:0]   rd_cnt_q, rd_cnt_d;
  logic [AW-1:0] first_err_q, first_err_d;
  logic          stray_q, stray_d;  // a read word showed up while still writing
  logic [AW-1:0] blk_base;

  // Pattern value stored at / expected from address a.
  function automatic logic [DW-1:0] exp_f(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = a[DW-1:0];
    if (MODE == 1) v = v ^ DW'(SEED);
    return v;
  endfunction

  // Next-state, next-output and checker logic; outputs are set one cycle
  // ahead so the registered FETCHING/CMD line up with the burst states.
  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    word_d      = word_q;
    drain_d     = drain_q;
    cmd_d       = CMD_NOP;
    fetching_d  = 1'b0;
    din_d       = din_q;
    addr_d      = addr_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timed_out_d = timed_out_q;
    err_cnt_d   = err_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    first_err_d = first_err_q;
    stray_d     = stray_q;
    blk_base    = BASE_ADDR + AW'(blk_q) * AW'(BL);

    // Read-back checker, live in every state but IDLE.
    if (state_q != IDLE && host.VALIDOUT) begin
      if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
      if (host.DOUT != exp_f(host.RADDR)) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        if (err_cnt_q == 16'd0) first_err_d = host.RADDR;
      end
      if (state_q inside {WAIT_RDY, WR_GATE, WR_BURST}) stray_d = 1'b1;
    end

    case (state_q)
      IDLE, DONE_S: begin
        // Late or surplus words keep PASS honest after completion.
        if (state_q == DONE_S)
          pass_d = (err_cnt_d == 16'd0) && !timed_out_q && !stray_d && (rd_cnt_d == TOTAL);
        if (START) begin
          err_cnt_d   = 16'd0;
          rd_cnt_d    = 16'd0;
          first_err_d = '0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          timed_out_d = 1'b0;
          stray_d     = 1'b0;
          busy_d      = 1'b1;
          blk_d       = '0;
          word_d      = '0;
          drain_d     = '0;
          state_d     = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (READY) state_d = WR_GATE;
      end
      WR_GATE: begin
        if (host.NOTFULL && int'(host.FILLCOUNT) <= WR_LIMIT) begin
          state_d    = WR_BURST;
          word_d     = '0;
          fetching_d = 1'b1;
          cmd_d      = CMD_BLW;
          addr_d     = blk_base;
          din_d      = exp_f(blk_base);
        end
      end
      WR_BURST: begin
        if (word_q == 6'(BL - 1)) begin
          word_d = '0;
          if (blk_q == 11'(NUM_BLK - 1)) begin
            blk_d   = '0;
            state_d = RD_GATE;
          end else begin
            blk_d   = blk_q + 11'd1;
            state_d = WR_GATE;
          end
        end else begin
          word_d     = word_q + 6'd1;
          fetching_d = 1'b1;
          cmd_d      = CMD_BLW;
          din_d      = exp_f(blk_base + AW'(word_q) + AW'(1));
        end
      end
      RD_GATE: begin
        if (host.NOTFULL && int'(host.FILLCOUNT) <= RD_LIMIT) begin
          state_d    = RD_ISSUE;
          fetching_d = 1'b1;
          cmd_d      = CMD_BLR;
          addr_d     = blk_base;
        end
      end
      RD_ISSUE: begin
        if (blk_q == 11'(NUM_BLK - 1)) begin
          drain_d = '0;
          state_d = DRAIN;
        end else begin
          blk_d   = blk_q + 11'd1;
          state_d = RD_GATE;
        end
      end
      DRAIN: begin
        // A word landing on the exit cycle is already folded into *_d.
        if (rd_cnt_q == TOTAL) begin
          state_d = DONE_S;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_cnt_d == 16'd0) && !stray_d && (rd_cnt_d == TOTAL);
        end else if (drain_q == 32'(TIMEOUT - 1)) begin
          state_d     = DONE_S;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          timed_out_d = 1'b1;
          pass_d      = 1'b0;
        end else begin
          drain_d = drain_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously so a reset aborts a run at once.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      blk_q       <= '0;
      word_q      <= '0;
      drain_q     <= '0;
      cmd_q       <= CMD_NOP;
      sz_q        <= SZ_CODE;
      fetching_q  <= 1'b0;
      din_q       <= '0;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timed_out_q <= 1'b0;
      err_cnt_q   <= '0;
      rd_cnt_q    <= '0;
      first_err_q <= '0;
      stray_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      word_q      <= word_d;
      drain_q     <= drain_d;
      cmd_q       <= cmd_d;
      sz_q        <= SZ_CODE;
      fetching_q  <= fetching_d;
      din_q       <= din_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timed_out_q <= timed_out_d;
      err_cnt_q   <= err_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      first_err_q <= first_err_d;
      stray_q     <= stray_d;
    end
  end

  assign host.CMD       = cmd_q;
  assign host.SZ        = sz_q;
  assign host.OP        = 3'b000;
  assign host.DIN       = din_q;
  assign host.ADDR      = addr_q;
  assign host.FETCHING  = fetching_q;
  assign BUSY           = busy_q;
  assign DONE           = done_q;
  assign PASS           = pass_q;
  assign TIMED_OUT      = timed_out_q;
  assign ERR_CNT        = err_cnt_q;
  assign RD_CNT         = rd_cnt_q;
  assign FIRST_ERR_ADDR = first_err_q;

endmodule

// File: tb/tb_ddr2_traffic_gen.sv
// Bench for ddr2_traffic_gen: three instances (default, XOR pattern, 32-word
// blocks) each with a loopback read model; command pushes are scoreboarded.
module tb_ddr2_traffic_gen;
  localparam logic [2:0] BLW = 3'b100;
  localparam logic [2:0] BLR = 3'b011;
  localparam logic [2:0] NOP = 3'b000;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [24:0] addr;
    logic [15:0] din;
  } sb_t;

  logic        clk = 1'b0;
  logic [2:0]  rst, start, ready;
  logic [2:0]  busy, done, pass, tmo;
  logic [15:0] err_cnt [3];
  logic [15:0] rd_cnt [3];
  logic [24:0] first_err [3];
  logic [2:0]  corrupt_en;
  logic [24:0] corrupt_addr;
  int          word_limit [3];
  int          checks = 0;
  int          errors = 0;
  sb_t         sb[$];

  always #5 clk = ~clk;

  ddr2_traffic_gen_if #(.DW(16), .AW(25), .FCW(7)) bus [3] ();

  ddr2_traffic_gen u0 (
    .CLK(clk), .RESET(rst[0]), .START(start[0]), .READY(ready[0]), .host(bus[0]),
    .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]), .TIMED_OUT(tmo[0]),
    .ERR_CNT(err_cnt[0]), .RD_CNT(rd_cnt[0]), .FIRST_ERR_ADDR(first_err[0])
  );

  ddr2_traffic_gen #(.MODE(1), .SEED(16'hA5C3)) u1 (
    .CLK(clk), .RESET(rst[1]), .START(start[1]), .READY(ready[1]), .host(bus[1]),
    .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]), .TIMED_OUT(tmo[1]),
    .ERR_CNT(err_cnt[1]), .RD_CNT(rd_cnt[1]), .FIRST_ERR_ADDR(first_err[1])
  );

  ddr2_traffic_gen #(.SZ_CODE(2'd3), .NUM_BLK(1)) u2 (
    .CLK(clk), .RESET(rst[2]), .START(start[2]), .READY(ready[2]), .host(bus[2]),
    .BUSY(busy[2]), .DONE(done[2]), .PASS(pass[2]), .TIMED_OUT(tmo[2]),
    .ERR_CNT(err_cnt[2]), .RD_CNT(rd_cnt[2]), .FIRST_ERR_ADDR(first_err[2])
  );

  function automatic logic [15:0] model_exp(input int idx, input logic [24:0] a);
    return (idx == 1) ? (a[15:0] ^ 16'hA5C3) : a[15:0];
  endfunction

  // Loopback controller: every block-read returns BL words of pattern data,
  // optionally corrupting one address or stopping after word_limit words.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_model
      localparam int BLM = (gi == 2) ? 32 : 8;
      logic [24:0] rq[$];
      logic [24:0] cur;
      int          rem;
      int          emitted;
      always @(negedge clk) begin
        if (rst[gi] || !busy[gi]) begin
          rq.delete();
          rem     = 0;
          emitted = 0;
          bus[gi].VALIDOUT = 1'b0;
          bus[gi].RADDR    = '0;
          bus[gi].DOUT     = '0;
        end else begin
          if (bus[gi].FETCHING === 1'b1 && bus[gi].CMD == BLR) rq.push_back(bus[gi].ADDR);
          bus[gi].VALIDOUT = 1'b0;
          if (rem == 0 && rq.size() > 0) begin
            cur = rq.pop_front();
            rem = BLM;
          end
          if (rem > 0) begin
            if (emitted < word_limit[gi]) begin
              bus[gi].VALIDOUT = 1'b1;
              bus[gi].RADDR    = cur;
              bus[gi].DOUT     = (corrupt_en[gi] && cur == corrupt_addr) ? 16'h0000 : model_exp(gi, cur);
              emitted++;
            end
            cur = cur + 25'd1;
            rem--;
          end
        end
      end
    end
  endgenerate

  task automatic pulse_start(input int i);
    @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 3'b111; start = 3'b000; ready = 3'b000;
    corrupt_en = 3'b000; corrupt_addr = '0;
    for (int i = 0; i < 3; i++) word_limit[i] = 1000;
    bus[0].FILLCOUNT = '0; bus[0].NOTFULL = 1'b1;
    bus[1].FILLCOUNT = '0; bus[1].NOTFULL = 1'b1;
    bus[2].FILLCOUNT = '0; bus[2].NOTFULL = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus[0].CMD !== NOP) begin errors++; $display("FAIL reset_cmd: got %0h want %0h", bus[0].CMD, NOP); end
    checks++;
    if (bus[0].SZ !== 2'd0 || bus[2].SZ !== 2'd3) begin errors++; $display("FAIL reset_sz: got %0d/%0d want 0/3", bus[0].SZ, bus[2].SZ); end
    checks++;
    if ({bus[0].FETCHING, busy[0], done[0], pass[0], tmo[0]} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {bus[0].FETCHING, busy[0], done[0], pass[0], tmo[0]});
    end
    checks++;
    if (err_cnt[0] !== 16'd0 || rd_cnt[0] !== 16'd0 || first_err[0] !== 25'd0) begin
      errors++; $display("FAIL reset_counters: got err=%0d rd=%0d first=%0h want 0/0/0", err_cnt[0], rd_cnt[0], first_err[0]);
    end
    checks++;
    if (bus[0].DIN !== 16'd0 || bus[0].ADDR !== 25'd0 || bus[0].OP !== 3'd0) begin
      errors++; $display("FAIL reset_bus: got din=%0h addr=%0h op=%0h want 0/0/0", bus[0].DIN, bus[0].ADDR, bus[0].OP);
    end
    rst = 3'b000;
    $display("test_reset done");
  endtask

  task automatic test_wait_ready;
    int bad, n;
    ready[0] = 1'b0;
    pulse_start(0);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy[0] !== 1'b1 || bus[0].FETCHING !== 1'b0 || bus[0].CMD !== NOP) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL wait_ready_idle: got %0d bad cycles want 0", bad); end
    ready[0] = 1'b1;
    n = 0;
    while (bus[0].FETCHING !== 1'b1 && n < 4) begin @(negedge clk); n++; end
    checks++;
    if (n > 2 || bus[0].FETCHING !== 1'b1) begin errors++; $display("FAIL ready_to_burst: got %0d cycles want <=2", n); end
    checks++;
    if (bus[0].CMD !== BLW || bus[0].ADDR !== 25'd0 || bus[0].DIN !== 16'd0) begin
      errors++; $display("FAIL first_word: got cmd=%0h addr=%0h din=%0h want 4/0/0", bus[0].CMD, bus[0].ADDR, bus[0].DIN);
    end
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    $display("test_wait_ready done: burst after %0d cycles", n);
  endtask

  task automatic test_loopback;
    int  n;
    sb_t e;
    sb.delete();
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 8; k++) sb.push_back('{BLW, 25'(b * 8), 16'(b * 8 + k)});
    for (int b = 0; b < 4; b++) sb.push_back('{BLR, 25'(b * 8), 16'h0});
    ready[0] = 1'b1;
    pulse_start(0);
    n = 0;
    while (done[0] !== 1'b1 && n < 2000) begin
      if (bus[0].FETCHING === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL loop_push_extra: got cmd=%0h addr=%0h want none", bus[0].CMD, bus[0].ADDR);
        end else begin
          e = sb.pop_front();
          if (bus[0].CMD !== e.cmd || bus[0].ADDR !== e.addr || (e.cmd == BLW && bus[0].DIN !== e.din)) begin
            errors++;
            $display("FAIL loop_push: got cmd=%0h addr=%0h din=%0h want cmd=%0h addr=%0h din=%0h",
                     bus[0].CMD, bus[0].ADDR, bus[0].DIN, e.cmd, e.addr, e.din);
          end
        end
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000 || sb.size() != 0) begin errors++; $display("FAIL loop_complete: got %0d cycles, %0d pushes missing want done", n, sb.size()); end
    checks++;
    if (done[0] !== 1'b1 || pass[0] !== 1'b1 || busy[0] !== 1'b0 || tmo[0] !== 1'b0) begin
      errors++; $display("FAIL loop_status: got done=%b pass=%b busy=%b tmo=%b want 1/1/0/0", done[0], pass[0], busy[0], tmo[0]);
    end
    checks++;
    if (rd_cnt[0] !== 16'd32 || err_cnt[0] !== 16'd0) begin
      errors++; $display("FAIL loop_counts: got rd=%0d err=%0d want 32/0", rd_cnt[0], err_cnt[0]);
    end
    $display("test_loopback done in %0d cycles", n);
  endtask

  task automatic test_mode1;
    int  n;
    sb_t e;
    sb.delete();
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 8; k++) sb.push_back('{BLW, 25'(b * 8), 16'(b * 8 + k) ^ 16'hA5C3});
    for (int b = 0; b < 4; b++) sb.push_back('{BLR, 25'(b * 8), 16'h0});
    corrupt_en[1] = 1'b1;
    corrupt_addr  = 25'h10;
    ready[1] = 1'b1;
    pulse_start(1);
    n = 0;
    while (done[1] !== 1'b1 && n < 2000) begin
      if (bus[1].FETCHING === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL xor_push_extra: got cmd=%0h addr=%0h want none", bus[1].CMD, bus[1].ADDR);
        end else begin
          e = sb.pop_front();
          if (bus[1].CMD !== e.cmd || bus[1].ADDR !== e.addr || (e.cmd == BLW && bus[1].DIN !== e.din)) begin
            errors++;
            $display("FAIL xor_push: got cmd=%0h addr=%0h din=%0h want cmd=%0h addr=%0h din=%0h",
                     bus[1].CMD, bus[1].ADDR, bus[1].DIN, e.cmd, e.addr, e.din);
          end
        end
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000 || done[1] !== 1'b1) begin errors++; $display("FAIL xor_complete: got %0d cycles want done", n); end
    checks++;
    if (err_cnt[1] !== 16'd1 || first_err[1] !== 25'h10) begin
      errors++; $display("FAIL xor_error: got err=%0d first=%0h want 1/10", err_cnt[1], first_err[1]);
    end
    checks++;
    if (pass[1] !== 1'b0 || rd_cnt[1] !== 16'd32) begin
      errors++; $display("FAIL xor_status: got pass=%b rd=%0d want 0/32", pass[1], rd_cnt[1]);
    end
    corrupt_en[1] = 1'b0;
    $display("test_mode1 done in %0d cycles", n);
  endtask

  task automatic test_gate;
    int bad, n, cnt, badw;
    bus[2].FILLCOUNT = 7'd31;
    ready[2] = 1'b1;
    pulse_start(2);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus[2].FETCHING !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || busy[2] !== 1'b1) begin errors++; $display("FAIL gate_hold: got %0d push cycles busy=%b want 0/1", bad, busy[2]); end
    bus[2].FILLCOUNT = 7'd30;
    n = 0;
    while (bus[2].FETCHING !== 1'b1 && n < 5) begin @(negedge clk); n++; end
    checks++;
    if (bus[2].FETCHING !== 1'b1) begin errors++; $display("FAIL gate_open: got no burst after %0d cycles want burst", n); end
    cnt = 0; badw = 0;
    while (bus[2].FETCHING === 1'b1 && cnt < 40) begin
      if (bus[2].CMD !== BLW || bus[2].ADDR !== 25'd0 || bus[2].DIN !== 16'(cnt)) badw++;
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != 32) begin errors++; $display("FAIL gate_burst_len: got %0d want 32", cnt); end
    checks++;
    if (badw != 0) begin errors++; $display("FAIL gate_burst_data: got %0d bad words want 0", badw); end
    rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0;
    $display("test_gate done: burst of %0d words", cnt);
  endtask

  task automatic test_timeout;
    int n, last_f;
    word_limit[0] = 24;
    pulse_start(0);
    checks++;
    if (done[0] !== 1'b0 || rd_cnt[0] !== 16'd0 || pass[0] !== 1'b0) begin
      errors++; $display("FAIL restart_clear: got done=%b rd=%0d pass=%b want 0/0/0", done[0], rd_cnt[0], pass[0]);
    end
    n = 0; last_f = 0;
    while (done[0] !== 1'b1 && n < 6000) begin
      if (bus[0].FETCHING === 1'b1) last_f = n;
      @(negedge clk);
      n++;
    end
    checks++;
    if (done[0] !== 1'b1 || tmo[0] !== 1'b1 || pass[0] !== 1'b0) begin
      errors++; $display("FAIL timeout_status: got done=%b tmo=%b pass=%b want 1/1/0", done[0], tmo[0], pass[0]);
    end
    checks++;
    if (rd_cnt[0] !== 16'd24) begin errors++; $display("FAIL timeout_rdcnt: got %0d want 24", rd_cnt[0]); end
    checks++;
    if (n - last_f < 4096 || n - last_f > 4098) begin
      errors++; $display("FAIL timeout_len: got %0d cycles after last push want 4096..4098", n - last_f);
    end
    word_limit[0] = 1000;
    $display("test_timeout done: %0d cycles after last push", n - last_f);
  endtask

  task automatic test_reset_mid_burst;
    int  n;
    sb_t e;
    pulse_start(0);
    n = 0;
    while (!(bus[0].FETCHING === 1'b1 && bus[0].DIN === 16'd3) && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL midrst_reach: got no word 3 want word 3"); end
    #1 rst[0] = 1'b1;
    #1;
    checks++;
    if ({bus[0].FETCHING, busy[0], done[0], pass[0], tmo[0]} !== 5'b0 || bus[0].CMD !== NOP) begin
      errors++; $display("FAIL midrst_flags: got %b cmd=%0h want 00000/0", {bus[0].FETCHING, busy[0], done[0], pass[0], tmo[0]}, bus[0].CMD);
    end
    checks++;
    if (bus[0].DIN !== 16'd0 || bus[0].ADDR !== 25'd0 || rd_cnt[0] !== 16'd0) begin
      errors++; $display("FAIL midrst_bus: got din=%0h addr=%0h rd=%0d want 0/0/0", bus[0].DIN, bus[0].ADDR, rd_cnt[0]);
    end
    @(negedge clk);
    rst[0] = 1'b0;
    sb.delete();
    for (int k = 0; k < 8; k++) sb.push_back('{BLW, 25'd0, 16'(k)});
    pulse_start(0);
    n = 0;
    while (done[0] !== 1'b1 && n < 2000) begin
      if (bus[0].FETCHING === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus[0].CMD !== e.cmd || bus[0].ADDR !== e.addr || bus[0].DIN !== e.din) begin
          errors++;
          $display("FAIL rerun_push: got cmd=%0h addr=%0h din=%0h want cmd=%0h addr=%0h din=%0h",
                   bus[0].CMD, bus[0].ADDR, bus[0].DIN, e.cmd, e.addr, e.din);
        end
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (done[0] !== 1'b1 || pass[0] !== 1'b1 || rd_cnt[0] !== 16'd32) begin
      errors++; $display("FAIL rerun_status: got done=%b pass=%b rd=%0d want 1/1/32", done[0], pass[0], rd_cnt[0]);
    end
    $display("test_reset_mid_burst done");
  endtask

  initial begin
    test_reset();
    test_wait_ready();
    test_loopback();
    test_mode1();
    test_gate();
    test_timeout();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
